// File: rtl/tdm_demux_1to4.sv
// Receiver side of the 4-slot TDM link: steers interleaved samples to channels
// D,C,B,A by slot code, tracks frame completeness and flags lost sync.
module tdm_demux_1to4 #(
    parameter int WIDTH     = 1,
    parameter bit AUTO_HUNT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             sync,
    input  logic             err_clr,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d,
    output logic [3:0]       stb,
    output logic             s1,
    output logic             s0,
    output logic             locked,
    output logic             frame_valid,
    output logic             sync_err
);

    typedef enum logic {HUNT = 1'b0, LOCK = 1'b1} state_t;

    state_t     state_reg, state_next;
    logic [1:0] slot_reg, slot_next;
    logic [3:0] mask_reg, mask_next;
    logic [3:0] stb_reg, wr_next;
    logic       fv_reg, fv_next;
    logic       sync_err_reg, sync_err_next;

    // Index 0 is channel D (slot 00) up to index 3 = channel A (slot 11),
    // so the write strobe for a slot is simply 1 << slot.
    logic [WIDTH-1:0] ch_reg [4];

    always_comb begin
        state_next    = state_reg;
        slot_next     = slot_reg;
        mask_next     = mask_reg;
        wr_next       = 4'b0000;
        fv_next       = 1'b0;
        sync_err_next = err_clr ? 1'b0 : sync_err_reg;

        if (din_valid) begin
            case (state_reg)
                HUNT: begin
                    if (sync) begin
                        wr_next    = 4'b0001;
                        slot_next  = 2'b01;
                        mask_next  = 4'b0001;
                        state_next = LOCK;
                    end
                end
                LOCK: begin
                    if (sync && (slot_reg != 2'b00)) begin
                        // Misplaced sync: an error raised here beats a same-cycle clear.
                        sync_err_next = 1'b1;
                        if (AUTO_HUNT) begin
                            state_next = HUNT;
                            slot_next  = 2'b00;
                            mask_next  = 4'b0000;
                        end else begin
                            wr_next   = 4'b0001;
                            slot_next = 2'b01;
                            mask_next = 4'b0001;
                        end
                    end else begin
                        wr_next   = 4'b0001 << slot_reg;
                        slot_next = slot_reg + 2'd1;
                        case (slot_reg)
                            2'b00:   mask_next = 4'b0001;
                            2'b11: begin
                                fv_next   = (mask_reg == 4'b0111);
                                mask_next = 4'b0000;
                            end
                            default: mask_next = mask_reg | wr_next;
                        endcase
                    end
                end
                default: state_next = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= HUNT;
            slot_reg     <= 2'b00;
            mask_reg     <= 4'b0000;
            stb_reg      <= 4'b0000;
            fv_reg       <= 1'b0;
            sync_err_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            slot_reg     <= slot_next;
            mask_reg     <= mask_next;
            stb_reg      <= wr_next;
            fv_reg       <= fv_next;
            sync_err_reg <= sync_err_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_ch
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ch_reg[gi] <= '0;
                end else if (wr_next[gi]) begin
                    ch_reg[gi] <= din;
                end
            end
        end
    endgenerate

    assign d           = ch_reg[0];
    assign c           = ch_reg[1];
    assign b           = ch_reg[2];
    assign a           = ch_reg[3];
    assign stb         = stb_reg;
    assign s1          = slot_reg[1];
    assign s0          = slot_reg[0];
    assign locked      = (state_reg == LOCK);
    assign frame_valid = fv_reg;
    assign sync_err    = sync_err_reg;

endmodule

// File: tb/tb_tdm_demux_1to4.sv
// Scoreboard bench: two demux instances (resync-in-place and auto-hunt) fed the
// same directed sample stream; strobed outputs are checked by a separate monitor.
module tb_tdm_demux_1to4;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] c;
        logic [3:0] d;
        logic [3:0] stb;
        logic       fv;
        logic       err;
        logic       lk;
        logic [1:0] sl;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] din;
    logic       din_valid;
    logic       sync;
    logic       err_clr;

    logic [3:0] a0, b0, c0, d0, stb0, a1, b1, c1, d1, stb1;
    logic       s10, s00, lk0, fv0, err0, s11, s01, lk1, fv1, err1;

    obs_t obs0, obs1;
    obs_t q0[$];
    obs_t q1[$];
    logic [3:0] sh0 [4];
    logic [3:0] sh1 [4];

    int n_cmp = 0;
    int n_bad = 0;

    tdm_demux_1to4 #(.WIDTH(4), .AUTO_HUNT(1'b0)) dut0 (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .sync(sync),
        .err_clr(err_clr), .a(a0), .b(b0), .c(c0), .d(d0), .stb(stb0),
        .s1(s10), .s0(s00), .locked(lk0), .frame_valid(fv0), .sync_err(err0)
    );

    tdm_demux_1to4 #(.WIDTH(4), .AUTO_HUNT(1'b1)) dut1 (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .sync(sync),
        .err_clr(err_clr), .a(a1), .b(b1), .c(c1), .d(d1), .stb(stb1),
        .s1(s11), .s0(s01), .locked(lk1), .frame_valid(fv1), .sync_err(err1)
    );

    assign obs0 = {a0, b0, c0, d0, stb0, fv0, err0, lk0, s10, s00};
    assign obs1 = {a1, b1, c1, d1, stb1, fv1, err1, lk1, s11, s01};

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic obs_t mk(input logic [3:0] sh [4], input logic [3:0] st,
                                input logic fv, input logic err, input logic lk,
                                input logic [1:0] sl);
        return {sh[3], sh[2], sh[1], sh[0], st, fv, err, lk, sl};
    endfunction

    // Monitor: whenever a DUT strobes, pop its expected frame and compare.
    always @(negedge clk) begin
        if (!rst) begin
            if (stb0 != 4'b0000) begin
                if (q0.size() == 0) begin
                    check("dut0 unexpected strobe", {28'd0, stb0}, 32'd0);
                end else begin
                    check("dut0 strobe", 32'(obs0), 32'(q0.pop_front()));
                end
                $display("dut0 txn stb=%b a=%h b=%h c=%h d=%h fv=%b err=%b slot=%b",
                         stb0, a0, b0, c0, d0, fv0, err0, {s10, s00});
            end else begin
                check("dut0 stray frame_valid", {31'd0, fv0}, 32'd0);
            end
            if (stb1 != 4'b0000) begin
                if (q1.size() == 0) begin
                    check("dut1 unexpected strobe", {28'd0, stb1}, 32'd0);
                end else begin
                    check("dut1 strobe", 32'(obs1), 32'(q1.pop_front()));
                end
                $display("dut1 txn stb=%b a=%h b=%h c=%h d=%h fv=%b err=%b slot=%b",
                         stb1, a1, b1, c1, d1, fv1, err1, {s11, s01});
            end else begin
                check("dut1 stray frame_valid", {31'd0, fv1}, 32'd0);
            end
        end
    end

    // One sample with the hand-computed response of each instance; then 'gap'
    // idle cycles where SYNC is toggled with DIN_VALID low to show it is ignored.
    task automatic send(input logic [3:0] v, input logic s, input logic clr, input int gap,
                        input logic [3:0] st0, input logic fve0, input logic erre0,
                        input logic lke0, input logic [1:0] sle0,
                        input logic [3:0] st1, input logic fve1, input logic erre1,
                        input logic lke1, input logic [1:0] sle1);
        obs_t e0, e1;
        @(negedge clk);
        din       = v;
        sync      = s;
        err_clr   = clr;
        din_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (st0[i]) sh0[i] = v;
            if (st1[i]) sh1[i] = v;
        end
        e0 = mk(sh0, st0, fve0, erre0, lke0, sle0);
        e1 = mk(sh1, st1, fve1, erre1, lke1, sle1);
        if (st0 != 4'b0000) q0.push_back(e0);
        if (st1 != 4'b0000) q1.push_back(e1);
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        sync      = 1'b0;
        err_clr   = 1'b0;
        if (st0 == 4'b0000) check("dut0 dropped sample", 32'(obs0), 32'(e0));
        if (st1 == 4'b0000) check("dut1 dropped sample", 32'(obs1), 32'(e1));
        repeat (gap) begin
            @(negedge clk);
            din  = 4'hF;
            sync = 1'b1;
            @(posedge clk);
            #1;
            sync = 1'b0;
        end
    endtask

    task automatic clr_pulse();
        @(negedge clk);
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        check("dut0 sync_err after clear", {31'd0, err0}, 32'd0);
        check("dut1 sync_err after clear", {31'd0, err1}, 32'd0);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: bench did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        din       = 4'h0;
        din_valid = 1'b0;
        sync      = 1'b0;
        err_clr   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sh0[i] = 4'h0;
            sh1[i] = 4'h0;
        end
        #3;
        check("dut0 reset state", 32'(obs0), 32'd0);
        check("dut1 reset state", 32'(obs1), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Hunting: unsynced samples are dropped
        send(4'h3, 0, 0, 0, 4'b0000, 0, 0, 0, 2'd0, 4'b0000, 0, 0, 0, 2'd0);
        send(4'h7, 0, 0, 0, 4'b0000, 0, 0, 0, 2'd0, 4'b0000, 0, 0, 0, 2'd0);

        // Back-to-back frame 1,2,3,4
        send(4'h1, 1, 0, 0, 4'b0001, 0, 0, 1, 2'd1, 4'b0001, 0, 0, 1, 2'd1);
        send(4'h2, 0, 0, 0, 4'b0010, 0, 0, 1, 2'd2, 4'b0010, 0, 0, 1, 2'd2);
        send(4'h3, 0, 0, 0, 4'b0100, 0, 0, 1, 2'd3, 4'b0100, 0, 0, 1, 2'd3);
        send(4'h4, 0, 0, 0, 4'b1000, 1, 0, 1, 2'd0, 4'b1000, 1, 0, 1, 2'd0);

        // Frame 5,6,7,8 with idle gaps between slots
        send(4'h5, 1, 0, 1, 4'b0001, 0, 0, 1, 2'd1, 4'b0001, 0, 0, 1, 2'd1);
        send(4'h6, 0, 0, 2, 4'b0010, 0, 0, 1, 2'd2, 4'b0010, 0, 0, 1, 2'd2);
        send(4'h7, 0, 0, 3, 4'b0100, 0, 0, 1, 2'd3, 4'b0100, 0, 0, 1, 2'd3);
        send(4'h8, 0, 0, 0, 4'b1000, 1, 0, 1, 2'd0, 4'b1000, 1, 0, 1, 2'd0);

        // Sync error at slot 10: dut0 resyncs in place, dut1 goes back to hunting
        send(4'h9, 1, 0, 0, 4'b0001, 0, 0, 1, 2'd1, 4'b0001, 0, 0, 1, 2'd1);
        send(4'hA, 0, 0, 0, 4'b0010, 0, 0, 1, 2'd2, 4'b0010, 0, 0, 1, 2'd2);
        send(4'hB, 1, 0, 0, 4'b0001, 0, 1, 1, 2'd1, 4'b0000, 0, 1, 0, 2'd0);
        send(4'hC, 0, 0, 0, 4'b0010, 0, 1, 1, 2'd2, 4'b0000, 0, 1, 0, 2'd0);
        send(4'hD, 0, 0, 0, 4'b0100, 0, 1, 1, 2'd3, 4'b0000, 0, 1, 0, 2'd0);
        send(4'hE, 0, 0, 0, 4'b1000, 1, 1, 1, 2'd0, 4'b0000, 0, 1, 0, 2'd0);
        clr_pulse();
        send(4'hF, 1, 0, 0, 4'b0001, 0, 0, 1, 2'd1, 4'b0001, 0, 0, 1, 2'd1);

        // New sync error together with ERR_CLR: the error wins
        send(4'h7, 1, 1, 0, 4'b0001, 0, 1, 1, 2'd1, 4'b0000, 0, 1, 0, 2'd0);
        clr_pulse();

        // Partial frame up to slot 10, then an asynchronous reset
        send(4'h1, 0, 0, 0, 4'b0010, 0, 0, 1, 2'd2, 4'b0000, 0, 0, 0, 2'd0);
        send(4'h2, 0, 0, 0, 4'b0100, 0, 0, 1, 2'd3, 4'b0000, 0, 0, 0, 2'd0);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("dut0 async reset", 32'(obs0), 32'd0);
        check("dut1 async reset", 32'(obs1), 32'd0);
        for (int i = 0; i < 4; i++) begin
            sh0[i] = 4'h0;
            sh1[i] = 4'h0;
        end
        @(negedge clk);
        rst = 1'b0;
        send(4'h1, 0, 0, 0, 4'b0000, 0, 0, 0, 2'd0, 4'b0000, 0, 0, 0, 2'd0);
        send(4'h2, 0, 0, 0, 4'b0000, 0, 0, 0, 2'd0, 4'b0000, 0, 0, 0, 2'd0);

        repeat (2) @(negedge clk);
        check("dut0 pending expectations", 32'(q0.size()), 32'd0);
        check("dut1 pending expectations", 32'(q1.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
